// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared CPU widths, ABI register indices and reset constants
package cpu_defs;
   localparam int XLEN       = 64;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   localparam int REG_ZERO = 0;
   localparam int REG_RA   = 1;
   localparam int REG_SP   = 2;
   localparam int REG_GP   = 3;

   localparam logic [XLEN-1:0] SP_RESET_DEFAULT = 64'h0000_7FF0;
endpackage

// File: rtl/register_file_64_if.sv
// rtl/register_file_64_if.sv - read/write port bundle of the integer register file
interface register_file_64_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 5
);
   logic [ADDR_WIDTH-1:0] read_reg1;
   logic [ADDR_WIDTH-1:0] read_reg2;
   logic [ADDR_WIDTH-1:0] write_reg;
   logic [DATA_WIDTH-1:0] write_data;
   logic                  reg_write;
   logic [DATA_WIDTH-1:0] read_data1;
   logic [DATA_WIDTH-1:0] read_data2;

   modport master (
      output read_reg1, read_reg2, write_reg, write_data, reg_write,
      input  read_data1, read_data2
   );

   modport slave (
      input  read_reg1, read_reg2, write_reg, write_data, reg_write,
      output read_data1, read_data2
   );
endinterface

// File: rtl/register_file_64_reg_read_port.sv
// rtl/register_file_64_reg_read_port.sv - one combinational read port with x0 gating
// and optional same-cycle write bypass
module reg_read_port
   import cpu_defs::*;
#(
   parameter int DATA_WIDTH = XLEN,
   parameter int ADDR_WIDTH = REG_ADDR_W,
   parameter bit BYPASS     = 1'b1
) (
   input  logic [ADDR_WIDTH-1:0]                       index,
   input  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0]    regs,
   input  logic                                        reg_write,
   input  logic [ADDR_WIDTH-1:0]                       write_reg,
   input  logic [DATA_WIDTH-1:0]                       write_data,
   output logic [DATA_WIDTH-1:0]                       data
);
   always_comb begin
      data = regs[index];
      // x0 gating wins over bypass, so a dropped write to x0 never leaks through
      if (index == ADDR_WIDTH'(REG_ZERO)) begin
         data = '0;
      end else if (BYPASS && reg_write && (write_reg == index)) begin
         data = write_data;
      end
   end
endmodule

// File: rtl/register_file_64.sv
// rtl/register_file_64.sv - 32 x 64-bit RISC-V integer register file, async reset,
// synchronous write, two combinational read ports
module register_file_64
   import cpu_defs::*;
#(
   parameter int                    DATA_WIDTH = XLEN,
   parameter int                    ADDR_WIDTH = REG_ADDR_W,
   parameter bit                    BYPASS     = 1'b1,
   parameter logic [DATA_WIDTH-1:0] SP_RESET   = DATA_WIDTH'(SP_RESET_DEFAULT)
) (
   input logic           clk,
   input logic           reset,
   register_file_64_if.slave bus
);
   localparam int NREGS = 2**ADDR_WIDTH;

   logic [NREGS-1:0][DATA_WIDTH-1:0] regs;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= (i == REG_SP) ? SP_RESET : '0;
         end
      end else if (bus.reg_write && (bus.write_reg != ADDR_WIDTH'(REG_ZERO))) begin
         regs[bus.write_reg] <= bus.write_data;
      end
   end

   reg_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .BYPASS     (BYPASS)
   ) u_port1 (
      .index      (bus.read_reg1),
      .regs       (regs),
      .reg_write  (bus.reg_write),
      .write_reg  (bus.write_reg),
      .write_data (bus.write_data),
      .data       (bus.read_data1)
   );

   reg_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .BYPASS     (BYPASS)
   ) u_port2 (
      .index      (bus.read_reg2),
      .regs       (regs),
      .reg_write  (bus.reg_write),
      .write_reg  (bus.write_reg),
      .write_data (bus.write_data),
      .data       (bus.read_data2)
   );
endmodule
